// File: rtl/vga_timing_gen_if.sv
// Signal bundle between the VGA scan generator, the character ROM and the DAC.
// The generator is the master: it drives addresses, syncs and colour, and samples Data.
interface vga_timing_gen_if;
    logic        Data;
    logic [10:0] Columnas;
    logic [9:0]  Filas;
    logic        HSYNC;
    logic        VSYNC;
    logic [3:0]  R;
    logic [3:0]  G;
    logic [3:0]  B;
    logic        Visible;
    logic        FrameStart;

    modport master (
        input  Data,
        output Columnas, Filas, HSYNC, VSYNC, R, G, B, Visible, FrameStart
    );

    modport slave (
        output Data,
        input  Columnas, Filas, HSYNC, VSYNC, R, G, B, Visible, FrameStart
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA scan initiator: column/row counters address the character ROM, and the
// returned pixel bit is turned into latency-aligned sync and 4:4:4 RGB.
module vga_timing_gen #(
    parameter int          H_VISIBLE = 800,
    parameter int          H_FP      = 56,
    parameter int          H_SYNC    = 120,
    parameter int          H_BP      = 64,
    parameter int          V_VISIBLE = 600,
    parameter int          V_FP      = 37,
    parameter int          V_SYNC    = 6,
    parameter int          V_BP      = 23,
    parameter bit          SYNC_POL  = 1'b1,
    parameter int          LATENCY   = 1,
    parameter logic [11:0] FG_COLOR  = 12'hFFF,
    parameter logic [11:0] BG_COLOR  = 12'h000
) (
    input  logic               CLK,
    input  logic               RST,
    vga_timing_gen_if.master   vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] HS_FIRST   = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_LAST    = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0]  VS_FIRST   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0]  VS_LAST    = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [10:0] r_col;
    logic [9:0]  r_row;
    logic        w_line_end;
    logic        w_frame_end;
    logic [2:0]  w_dec;       // {vis, hs, vs} for the position presented now
    logic [2:0]  w_dec_d;     // same decode, aligned with the Data sample edge

    logic        r_vis;
    logic        r_hsync;
    logic        r_vsync;
    logic [11:0] r_rgb;
    logic        r_frame_start;

    assign w_line_end  = (r_col == H_LAST);
    assign w_frame_end = w_line_end && (r_row == V_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_col <= 11'd0;
            r_row <= 10'd0;
        end else if (w_line_end) begin
            r_col <= 11'd0;
            r_row <= w_frame_end ? 10'd0 : r_row + 10'd1;
        end else begin
            r_col <= r_col + 11'd1;
        end
    end

    always_comb begin
        w_dec    = 3'b000;
        w_dec[2] = (r_col < H_VIS_END) && (r_row < V_VIS_END);
        w_dec[1] = (r_col >= HS_FIRST) && (r_col <= HS_LAST);
        w_dec[0] = (r_row >= VS_FIRST) && (r_row <= VS_LAST);
    end

    // The output register is the last stage of the LATENCY-deep decode pipeline,
    // so only LATENCY-1 extra stages sit in front of it.
    if (LATENCY > 1) begin : g_dly
        logic [2:0] r_dly [LATENCY-1];

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                for (int i = 0; i < LATENCY - 1; i++) begin
                    r_dly[i] <= 3'b000;
                end
            end else begin
                r_dly[0] <= w_dec;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    r_dly[i] <= r_dly[i-1];
                end
            end
        end

        assign w_dec_d = r_dly[LATENCY-2];
    end else begin : g_nodly
        assign w_dec_d = w_dec;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_vis         <= 1'b0;
            r_hsync       <= !SYNC_POL;
            r_vsync       <= !SYNC_POL;
            r_rgb         <= 12'h000;
            r_frame_start <= 1'b0;
        end else begin
            r_vis         <= w_dec_d[2];
            r_hsync       <= w_dec_d[1] ? SYNC_POL : !SYNC_POL;
            r_vsync       <= w_dec_d[0] ? SYNC_POL : !SYNC_POL;
            r_rgb         <= !w_dec_d[2] ? 12'h000 : (vga.Data ? FG_COLOR : BG_COLOR);
            r_frame_start <= w_frame_end;
        end
    end

    assign vga.Columnas   = r_col;
    assign vga.Filas      = r_row;
    assign vga.Visible    = r_vis;
    assign vga.HSYNC      = r_hsync;
    assign vga.VSYNC      = r_vsync;
    assign vga.R          = r_rgb[11:8];
    assign vga.G          = r_rgb[7:4];
    assign vga.B          = r_rgb[3:0];
    assign vga.FrameStart = r_frame_start;

endmodule
